// File: rtl/mem_access.sv
// mem_access: memory stage running one handshaked data-bus transaction per load/store,
// with load lane extraction. Define MEM_TIMEOUT_EN to build the ack timeout (ACK_TIMEOUT).
module mem_access #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   input  logic [3:0]  mem_op_i,
   input  logic [4:0]  reg_waddr_i,
   input  logic        reg_we_i,
   input  logic [31:0] reg_wdata_i,
   input  logic        hold_i,
   input  logic [31:0] dbus_rdata_i,
   input  logic        dbus_ack_i,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output logic [31:0] dbus_wdata_o,
   output logic [3:0]  dbus_be_o,
   output logic        stall_req_o,
   output logic [4:0]  reg_waddr_o,
   output logic        reg_we_o,
   output logic [31:0] reg_wdata_o,
   output logic        misalign_o,
   output logic        bus_err_o
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;

   state_e      state_q, state_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_q, load_d;
   logic [3:0]  be_q, be_d, op_q, op_d;
   logic [1:0]  lane_q, lane_d;
   logic        is_load_q, is_load_d, misalign_q, misalign_d, kill_q, kill_d;

   logic        op_load_s, op_store_s, op_byte_s, op_half_s, op_word_s;
   logic        access_s, misaligned_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s;
   logic        unused_s;

   // mem_we_i duplicates the store encoding already carried by the opcode.
   assign unused_s = mem_we_i;

   function automatic logic [31:0] extract_load(input logic [3:0] op, input logic [1:0] lane,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (op)
         4'd1:    extract_load = {{24{b[7]}}, b};
         4'd2:    extract_load = {{16{h[15]}}, h};
         4'd4:    extract_load = {24'h000000, b};
         4'd5:    extract_load = {16'h0000, h};
         default: extract_load = word;
      endcase
   endfunction

   always_comb begin
      op_load_s  = 1'b0;
      op_store_s = 1'b0;
      op_byte_s  = 1'b0;
      op_half_s  = 1'b0;
      op_word_s  = 1'b0;
      case (mem_op_i)
         4'd1, 4'd4: begin op_load_s = 1'b1;  op_byte_s = 1'b1; end
         4'd2, 4'd5: begin op_load_s = 1'b1;  op_half_s = 1'b1; end
         4'd3:       begin op_load_s = 1'b1;  op_word_s = 1'b1; end
         4'd6:       begin op_store_s = 1'b1; op_byte_s = 1'b1; end
         4'd7:       begin op_store_s = 1'b1; op_half_s = 1'b1; end
         4'd8:       begin op_store_s = 1'b1; op_word_s = 1'b1; end
         default:    begin op_load_s = 1'b0; end
      endcase
   end

   assign access_s     = op_load_s | op_store_s;
   assign misaligned_s = (op_half_s & mem_addr_i[0]) | (op_word_s & (mem_addr_i[1:0] != 2'b00));

   always_comb begin
      be_s    = 4'hF;
      wdata_s = 32'h0000_0000;
      if (op_store_s && op_byte_s) begin
         be_s    = 4'b0001 << mem_addr_i[1:0];
         wdata_s = {4{mem_data_i[7:0]}};
      end else if (op_store_s && op_half_s) begin
         be_s    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
         wdata_s = {2{mem_data_i[15:0]}};
      end else if (op_store_s) begin
         wdata_s = mem_data_i;
      end else begin
         wdata_s = 32'h0000_0000;
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      op_d       = op_q;
      lane_d     = lane_q;
      is_load_d  = is_load_q;
      load_d     = load_q;
      kill_d     = kill_q;
      misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (access_s) begin
               op_d      = mem_op_i;
               lane_d    = mem_addr_i[1:0];
               is_load_d = op_load_s;
               load_d    = 32'h0000_0000;
               if (misaligned_s) begin
                  state_d    = S_DONE;
                  misalign_d = 1'b1;
                  kill_d     = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  req_d   = 1'b1;
                  we_d    = op_store_s;
                  addr_d  = {mem_addr_i[31:2], 2'b00};
                  be_d    = be_s;
                  wdata_d = wdata_s;
                  kill_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
                  cnt_d   = 8'd0;
`endif
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            // Ack is checked first so it wins over a simultaneous timeout.
            if (dbus_ack_i) begin
               req_d   = 1'b0;
               state_d = S_DONE;
               load_d  = is_load_q ? extract_load(op_q, lane_q, dbus_rdata_i) : 32'h0000_0000;
`ifdef MEM_TIMEOUT_EN
            end else if (cnt_q == ACK_LAST) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               kill_d  = 1'b1;
               load_d  = 32'h0000_0000;
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + 8'd1;
`else
            end else begin
               state_d = S_WAIT;
`endif
            end
         end
         S_DONE: begin
            if (!hold_i) begin
               state_d = S_IDLE;
               kill_d  = 1'b0;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0000_0000;
         wdata_q    <= 32'h0000_0000;
         be_q       <= 4'h0;
         op_q       <= 4'h0;
         lane_q     <= 2'b00;
         is_load_q  <= 1'b0;
         load_q     <= 32'h0000_0000;
         kill_q     <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         op_q       <= op_d;
         lane_q     <= lane_d;
         is_load_q  <= is_load_d;
         load_q     <= load_d;
         kill_q     <= kill_d;
         misalign_q <= misalign_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   assign bus_err_o = err_q;
`else
   assign bus_err_o = 1'b0;
`endif

   always_comb begin
      stall_req_o = 1'b0;
      reg_waddr_o = reg_waddr_i;
      reg_we_o    = reg_we_i;
      reg_wdata_o = reg_wdata_i;
      if (rst_i) begin
         stall_req_o = 1'b0;
         reg_we_o    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (access_s) begin
                  stall_req_o = 1'b1;
                  reg_we_o    = 1'b0;
               end else begin
                  stall_req_o = 1'b0;
               end
            end
            S_WAIT: begin
               stall_req_o = 1'b1;
               reg_we_o    = 1'b0;
            end
            S_DONE: begin
               reg_we_o    = reg_we_i & ~kill_q;
               reg_wdata_o = is_load_q ? load_q : reg_wdata_i;
            end
            default: stall_req_o = 1'b0;
         endcase
      end
   end

   assign dbus_req_o   = req_q;
   assign dbus_we_o    = we_q;
   assign dbus_addr_o  = addr_q;
   assign dbus_wdata_o = wdata_q;
   assign dbus_be_o    = be_q;
   assign misalign_o   = misalign_q;
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected bus/result records, a monitor pops them.
module tb_mem_access;
   logic        clk = 1'b0;
   logic        rst_i, mem_we_i, reg_we_i, hold_i, dbus_ack_i;
   logic [31:0] mem_addr_i, mem_data_i, reg_wdata_i, dbus_rdata_i;
   logic [3:0]  mem_op_i;
   logic [4:0]  reg_waddr_i;
   logic        dbus_req_o, dbus_we_o, stall_req_o, reg_we_o, misalign_o, bus_err_o;
   logic [31:0] dbus_addr_o, dbus_wdata_o, reg_wdata_o;
   logic [3:0]  dbus_be_o;
   logic [4:0]  reg_waddr_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; logic chk_wdata;
   } bus_exp_t;
   typedef struct {
      logic we; logic [31:0] wdata; logic misalign; logic err;
   } res_exp_t;
   bus_exp_t bus_q[$];
   res_exp_t res_q[$];

   always #5 clk = ~clk;

   mem_access #(.ACK_TIMEOUT(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
      .mem_data_i(mem_data_i), .mem_op_i(mem_op_i), .reg_waddr_i(reg_waddr_i),
      .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i), .hold_i(hold_i),
      .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i), .dbus_req_o(dbus_req_o),
      .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
      .dbus_be_o(dbus_be_o), .stall_req_o(stall_req_o), .reg_waddr_o(reg_waddr_o),
      .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o), .misalign_o(misalign_o),
      .bus_err_o(bus_err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: bus fields at each handshake, write-back triple on the first cycle after a stall.
   initial begin : monitor
      bus_exp_t be_e;
      res_exp_t re;
      logic     stall_prev;
      stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            stall_prev = 1'b0;
         end else begin
            if (dbus_req_o && dbus_ack_i) begin
               if (bus_q.size() == 0) begin
                  chk("bus_unexpected", 32'd1, 32'd0);
               end else begin
                  be_e = bus_q.pop_front();
                  chk("bus_addr", dbus_addr_o, be_e.addr);
                  chk("bus_we", {31'd0, dbus_we_o}, {31'd0, be_e.we});
                  chk("bus_be", {28'd0, dbus_be_o}, {28'd0, be_e.be});
                  if (be_e.chk_wdata) chk("bus_wdata", dbus_wdata_o, be_e.wdata);
               end
            end
            if (stall_prev && !stall_req_o) begin
               if (res_q.size() == 0) begin
                  chk("res_unexpected", 32'd1, 32'd0);
               end else begin
                  re = res_q.pop_front();
                  chk("res_we", {31'd0, reg_we_o}, {31'd0, re.we});
                  chk("res_wdata", reg_wdata_o, re.wdata);
                  chk("res_misalign", {31'd0, misalign_o}, {31'd0, re.misalign});
                  chk("res_bus_err", {31'd0, bus_err_o}, {31'd0, re.err});
                  chk("res_waddr", {27'd0, reg_waddr_o}, 32'd7);
               end
            end
            stall_prev = stall_req_o;
         end
      end
   end

   task automatic run_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
         input logic [31:0] data, input logic [31:0] rdata, input logic rwe, input logic [31:0] rwdata,
         input int ack_delay, input int hold_cycles, input int exp_stall, input int exp_reqs,
         input logic [31:0] exp_baddr, input logic [3:0] exp_be, input logic [31:0] exp_bwdata,
         input logic exp_bwe, input logic exp_we, input logic [31:0] exp_wdata,
         input logic exp_mis, input logic exp_err, output int wait_cycles);
      int   stall_cnt, reqs;
      logic prev_req, done;
      bus_exp_t b;
      res_exp_t r;
      @(posedge clk); #1;
      mem_op_i = op; mem_addr_i = addr; mem_data_i = data; dbus_rdata_i = rdata;
      mem_we_i = (op >= 4'd6 && op <= 4'd8); reg_we_i = rwe; reg_wdata_i = rwdata;
      reg_waddr_i = 5'd7; hold_i = (hold_cycles > 0); dbus_ack_i = 1'b0;
      if (exp_reqs == 1 && ack_delay > 0) begin
         b.addr = exp_baddr; b.we = exp_bwe; b.be = exp_be; b.wdata = exp_bwdata;
         b.chk_wdata = exp_bwe;
         bus_q.push_back(b);
      end
      r.we = exp_we; r.wdata = exp_wdata; r.misalign = exp_mis; r.err = exp_err;
      res_q.push_back(r);
      stall_cnt = 0; reqs = 0; wait_cycles = 0; prev_req = 1'b0; done = 1'b0;
      @(negedge clk);
      if (stall_req_o) stall_cnt++;
      for (int c = 0; c < 40 && !done; c++) begin
         @(posedge clk); #1;
         if (dbus_req_o && !prev_req) reqs++;
         prev_req = dbus_req_o;
         if (dbus_req_o) begin
            wait_cycles++;
            dbus_ack_i = (wait_cycles == ack_delay);
         end else begin
            dbus_ack_i = 1'b0;
         end
         @(negedge clk);
         if (stall_req_o) stall_cnt++;
         else done = 1'b1;
      end
      chk({tag, "_completed"}, {31'd0, done}, 32'd1);
      chk({tag, "_stall_cycles"}, stall_cnt, exp_stall);
      chk({tag, "_bus_requests"}, reqs, exp_reqs);
      #1;
      hold_i = (hold_cycles >= 1);
      if (!hold_i) mem_op_i = 4'd0;
      for (int dd = 2; dd <= hold_cycles + 1; dd++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk({tag, "_hold_stall"}, {31'd0, stall_req_o}, 32'd0);
         chk({tag, "_hold_wdata"}, reg_wdata_o, exp_wdata);
         chk({tag, "_hold_we"}, {31'd0, reg_we_o}, {31'd0, exp_we});
         chk({tag, "_hold_flags"}, {30'd0, misalign_o, bus_err_o}, 32'd0);
         chk({tag, "_hold_req"}, {31'd0, dbus_req_o}, 32'd0);
         #1;
         hold_i = (dd <= hold_cycles);
         if (!hold_i) mem_op_i = 4'd0;
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_idle_stall"}, {31'd0, stall_req_o}, 32'd0);
      chk({tag, "_idle_we_pass"}, {31'd0, reg_we_o}, {31'd0, rwe});
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int wc;
      rst_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0; mem_data_i = 32'h0;
      mem_op_i = 4'd3; reg_waddr_i = 5'd7; reg_we_i = 1'b1; reg_wdata_i = 32'h0;
      hold_i = 1'b0; dbus_rdata_i = 32'h0; dbus_ack_i = 1'b0;
      @(negedge clk);
      chk("rst_bus", {dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o[25:0]}, 32'd0);
      chk("rst_wdata", dbus_wdata_o, 32'd0);
      chk("rst_flags", {30'd0, misalign_o, bus_err_o}, 32'd0);
      chk("rst_stall_we", {30'd0, stall_req_o, reg_we_o}, 32'd0);
      @(posedge clk); #1;
      rst_i = 1'b0; mem_op_i = 4'd0;

      // NOP pass-through (including opcode 12) with a stray ack that must be ignored.
      @(posedge clk); #1;
      mem_op_i = 4'd12; reg_we_i = 1'b1; reg_wdata_i = 32'hCAFE_0001; reg_waddr_i = 5'd3;
      dbus_ack_i = 1'b1;
      #1;
      chk("nop_pass", {reg_waddr_o, reg_we_o, stall_req_o}, {25'd0, 5'd3, 1'b1, 1'b0});
      chk("nop_wdata", reg_wdata_o, 32'hCAFE_0001);
      @(posedge clk); #1;
      mem_op_i = 4'd0;
      @(negedge clk);
      chk("idle_ack_ignored", {30'd0, dbus_req_o, stall_req_o}, 32'd0);
      @(posedge clk); #1;
      dbus_ack_i = 1'b0;

      run_access("lb", 4'd1, 32'h103, 32'h0, 32'h80FF_FF7F, 1'b1, 32'h1111, 1, 0, 2, 1,
                 32'h100, 4'hF, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, wc);
      run_access("sh", 4'd7, 32'h202, 32'h1234_ABCD, 32'h0, 1'b0, 32'hDEAD_0001, 1, 0, 2, 1,
                 32'h200, 4'hC, 32'hABCD_ABCD, 1'b1, 1'b0, 32'hDEAD_0001, 1'b0, 1'b0, wc);
      run_access("lw_mis", 4'd3, 32'h101, 32'h0, 32'h0, 1'b1, 32'h2222, 1, 0, 1, 0,
                 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, wc);
      run_access("lhu_hold", 4'd5, 32'h10, 32'h0, 32'h1357_9BDF, 1'b1, 32'h3333, 5, 2, 6, 1,
                 32'h10, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0000_9BDF, 1'b0, 1'b0, wc);
      chk("lhu_wait_cycles", wc, 32'd5);
      run_access("sb", 4'd6, 32'h305, 32'hFFFF_FF55, 32'h0, 1'b0, 32'h4444, 2, 0, 3, 1,
                 32'h304, 4'b0010, 32'h5555_5555, 1'b1, 1'b0, 32'h4444, 1'b0, 1'b0, wc);
      run_access("lh", 4'd2, 32'h6, 32'h0, 32'h8001_1234, 1'b1, 32'h5555, 1, 0, 2, 1,
                 32'h4, 4'hF, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0, wc);
      run_access("lbu", 4'd4, 32'h1, 32'h0, 32'h0000_F000, 1'b1, 32'h6666, 1, 0, 2, 1,
                 32'h0, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0000_00F0, 1'b0, 1'b0, wc);
      run_access("sh_mis", 4'd7, 32'h1, 32'h0, 32'h0, 1'b1, 32'h7777, 1, 1, 1, 0,
                 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h7777, 1'b1, 1'b0, wc);

      // Reset mid-WAIT drops the request and the stall without a clock edge.
      @(posedge clk); #1;
      mem_op_i = 4'd8; mem_we_i = 1'b1; mem_addr_i = 32'h400; mem_data_i = 32'h1;
      reg_we_i = 1'b1; hold_i = 1'b0; dbus_ack_i = 1'b0;
      @(posedge clk); #1;
      chk("rstwait_req_before", {31'd0, dbus_req_o}, 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("rstwait_req_dropped", {31'd0, dbus_req_o}, 32'd0);
      chk("rstwait_stall_we", {30'd0, stall_req_o, reg_we_o}, 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_i = 1'b0; mem_op_i = 4'd0;
      run_access("sw_after_rst", 4'd8, 32'h404, 32'hA5A5_A5A5, 32'h0, 1'b0, 32'h8888, 1, 0, 2, 1,
                 32'h404, 4'hF, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h8888, 1'b0, 1'b0, wc);

`ifdef MEM_TIMEOUT_EN
      run_access("timeout", 4'd3, 32'h500, 32'h0, 32'h0, 1'b1, 32'h9999, 0, 0, 5, 1,
                 32'h500, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, wc);
      chk("timeout_wait_cycles", wc, 32'd4);
`endif

      @(posedge clk); #1;
      chk("bus_q_drained", bus_q.size(), 32'd0);
      chk("res_q_drained", res_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
